// File: rtl/icache_dm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : icache_dm                                                        |
// | Brief   : Direct-mapped, one-word-per-line instruction cache with          |
// |           req/ack refill and saturating hit/miss counters.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module icache_dm #(
  parameter int WORD = 32,
  parameter int ADDR = 16,
  parameter int IDX  = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ADDR-1:0] addr_i,
  input  logic            en_i,
  output logic [WORD-1:0] inst_o,
  output logic            hit_o,
  output logic            stall_o,
  input  logic            inv_i,
  output logic            mem_req_o,
  output logic [ADDR-1:0] mem_addr_o,
  input  logic            mem_ack_i,
  input  logic [WORD-1:0] mem_data_i,
  output logic [CNTW-1:0] hit_cnt_o,
  output logic [CNTW-1:0] miss_cnt_o
);

  localparam int              LINES     = 1 << IDX;
  localparam int              TAGW      = ADDR - IDX;
  localparam logic [CNTW-1:0] c_cnt_max = '1;
  localparam logic [CNTW-1:0] c_cnt_one = CNTW'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WORD-1:0]  r_data [LINES];
  logic [TAGW-1:0]  r_tag  [LINES];
  logic [LINES-1:0] r_valid;

  logic [IDX-1:0]   w_idx;
  logic [TAGW-1:0]  w_tag;
  logic [IDX-1:0]   w_fill_idx;
  logic [TAGW-1:0]  w_fill_tag;
  logic             w_idle;
  logic             w_miss;
  logic             w_fill;

  assign w_idx      = addr_i[IDX-1:0];
  assign w_tag      = addr_i[ADDR-1:IDX];
  assign w_fill_idx = mem_addr_o[IDX-1:0];
  assign w_fill_tag = mem_addr_o[ADDR-1:IDX];

  assign hit_o   = en_i & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign inst_o  = hit_o ? r_data[w_idx] : '0;
  assign w_idle  = (r_state == ST_IDLE);
  assign w_miss  = w_idle & en_i & ~hit_o;
  assign w_fill  = (r_state == ST_REQ) & mem_ack_i;
  // Gated by rst so the fetch stage never sees a stall while the cache is held in reset.
  assign stall_o = rst & (~w_idle | w_miss);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_miss) begin
            r_state    <= ST_REQ;
            mem_req_o  <= 1'b1;
            mem_addr_o <= addr_i;
          end
        end
        ST_REQ: begin
          if (mem_ack_i) begin
            r_state   <= ST_IDLE;
            mem_req_o <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

  // Invalidate takes priority over a coinciding fill, leaving the line invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
    end else if (inv_i) begin
      r_valid <= '0;
    end else if (w_fill) begin
      r_valid[w_fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_fill_idx] <= mem_data_i;
      r_tag[w_fill_idx]  <= w_fill_tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (w_idle && hit_o && (hit_cnt_o != c_cnt_max)) begin
        hit_cnt_o <= hit_cnt_o + c_cnt_one;
      end
      if (w_miss && (miss_cnt_o != c_cnt_max)) begin
        miss_cnt_o <= miss_cnt_o + c_cnt_one;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, one-word-per-line instruction cache.
- Acts as the responder to the fetch stage: receives the fetch word address and returns the instruction in the same cycle on a hit.
- On a miss, asserts stall to the fetch stage and refills the line from external instruction memory over a req/ack handshake.
- Also keeps saturating hit/miss counters for performance monitoring.

Parameters:
- WORD, 32, instruction width in bits.
- ADDR, 16, word-address width; the fetch stage increments the address by 1 per instruction.
- IDX, 4, index bits; 2^IDX lines. Tag width is ADDR-IDX.
- CNTW, 16, width of the hit/miss counters.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- addr_i  input  ADDR  fetch word address, driven from the fetch stage's address register.
- en_i  input  1  fetch lookup valid. When 0, no lookup, no miss, no counting.
- inst_o  output  WORD  instruction for addr_i. Valid in the same cycle when hit_o=1.
- hit_o  output  1  combinational: en_i & valid[idx] & tag match.
- stall_o  output  1  to the fetch stage; 1 while the requested word is not available.
- inv_i  input  1  invalidate all lines (pulse).
- mem_req_o  output  1  external read request.
- mem_addr_o  output  ADDR  external read word address (registered).
- mem_ack_i  input  1  external data valid; sampled on the posedge.
- mem_data_i  input  WORD  external read data; captured when mem_ack_i=1.
- hit_cnt_o  output  CNTW  saturating count of hit cycles.
- miss_cnt_o  output  CNTW  saturating count of misses (one per refill started).

Behaviour:
- Address split: idx = addr_i[IDX-1:0]; tag = addr_i[ADDR-1:IDX].
- Storage: data, tag and valid arrays in flops. Lookup read is combinational.
- inst_o = data[idx] when hit_o=1, else all zeros.
- Reset (rst low, asynchronous):
  - all valid bits cleared; state = IDLE.
  - mem_req_o=0, mem_addr_o=0, counters=0.
  - stall_o forced to 0 while rst is low.
- FSM states: IDLE, REQ.
  - IDLE: stall_o = en_i & ~hit_o.
    - On a miss (en_i & ~hit_o): at the next posedge, mem_addr_o <= addr_i, mem_req_o <= 1, state -> REQ, miss_cnt +1.
  - REQ: stall_o = 1; mem_req_o held at 1 and mem_addr_o held stable until ack.
    - On a posedge with mem_ack_i=1: data[mem_addr_o idx] <= mem_data_i; tag <= mem_addr_o tag; valid <= 1; mem_req_o <= 0; state -> IDLE.
- Miss latency: miss seen in cycle 0; req high from cycle 1; ack sampled at cycle k; cycle k+1 is IDLE and the lookup hits, so stall_o=0 and inst_o is valid. Total stall = k+1 cycles.
- The fill is always written using the latched mem_addr_o, never the current addr_i.
  - If addr_i changed during REQ, IDLE re-evaluates in cycle k+1 and may miss again.
- The fetch stage holds addr_i while stall_o=1. The cache still does not depend on that.
- en_i dropping during REQ: the refill still completes; stall_o is 0 in IDLE while en_i=0.
- inv_i:
  - At the next posedge, all valid bits are cleared.
  - If inv_i and a fill ack coincide, invalidate wins: the filled line is left invalid, state -> IDLE, and the next lookup misses again.
  - inv_i in IDLE with a concurrent miss: the miss is still started.
- hit_cnt +1 on every posedge with hit_o=1 in IDLE.
- Both counters saturate at 2^CNTW-1 and do not wrap.
- Aliasing: two addresses with the same idx evict each other. A refill overwrites the line unconditionally.
- No outstanding-request overlap: at most one refill in flight.

Test Plan:
- Reset, then en_i=1, addr_i=0x0010, mem ack 3 cycles after req with data 0xDEADBEEF -> stall_o=1 for 4 cycles, mem_addr_o=0x0010; next cycle hit_o=1, inst_o=0xDEADBEEF, miss_cnt=1.
- After fill, sequential fetch 0x0010 repeated 5 cycles -> stall_o=0 every cycle, hit_cnt=5. Then addr 0x0020 (same idx 0, different tag) -> miss, refill; then 0x0010 -> misses again (eviction).
- Assert inv_i one cycle after a line is filled -> following lookup of the same address gives hit_o=0, stall_o=1, new mem_req_o.
- inv_i asserted on the same edge as mem_ack_i -> state returns to IDLE, line invalid, a second request is issued for the same address.
- Drop rst mid-REQ -> mem_req_o=0 and stall_o=0 immediately (asynchronously), counters=0; after release, a lookup of the previously filled address misses.
- Force miss_cnt to 0xFFFF via 65535+ misses (or a bench-reduced CNTW=4: 16 misses) -> the counter holds at its maximum and does not wrap to 0.
